fetch_prefetch_stage: RTL and testbench

Instruction fetch stage that sits directly upstream of the decode stage. It owns the program counter and issues requests to an instruction memory through a ready/valid handshake. Returned instructions go into a small prefetch queue, and the stage drives the IF/ID register (`InstrD`, `PCD`, `PCPlus4D`). It obeys the hazard unit's `StallD` and the execute stage's redirect (`PCSrcE`/`PCTargetE`), and discards wrong-path instructions that are already queued or still in flight.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_prefetch_stage_if.sv | 33 +++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_prefetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_prefetch_stage.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: datapath width,
// the NOP used for decode bubbles, the default reset PC and the
// {instr, pc} prefetch queue entry.
package fetch_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One prefetch queue entry: fetched instruction plus its PC.
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_stage_if.sv
// Instruction memory request/response bus.
//   imem_req    request valid (fetch stage -> memory)
//   imem_addr   request address
//   imem_ready  memory accepts the request this cycle
//   imem_rvalid response valid, responses return in order
//   imem_rdata  response instruction
// master: fetch stage side, slave: memory side.
interface fetch_prefetch_stage_if;
   import fetch_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH x {instr, pc}, synchronous push/pop/flush.
//   clk, rst      clock, async active-high reset
//   push, wdata   write an entry
//   pop, rdata    rdata is the current head; pop removes it
//   flush         synchronously empties the queue (wins over push/pop)
//   count         number of valid entries
//   empty, full   status flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  fetch_entry_t             wdata,
   input  logic                     pop,
   output fetch_entry_t             rdata,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   fetch_entry_t    mem [DEPTH];
   logic [PW-1:0]   wptr;
   logic [PW-1:0]   rptr;

   // Pointer update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
      end
   end

   // Storage, no reset needed
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[AW-1:0]];
   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/fetch_prefetch_stage.sv
// Instruction fetch stage with prefetch queue, feeding the IF/ID register.
//   clk, rst            clock, async active-high reset
//   PCSrcE, PCTargetE   redirect from execute (flushes queue, drops in-flight)
//   StallD              hold the IF/ID register
//   imem                instruction memory bus (master side)
//   InstrD, PCD,
//   PCPlus4D, ValidD    IF/ID register; ValidD = 0 marks a bubble (NOP)
module fetch_prefetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     PCSrcE,
   input  logic [XLEN-1:0]          PCTargetE,
   input  logic                     StallD,
   fetch_prefetch_stage_if.master   imem,
   output logic [XLEN-1:0]          InstrD,
   output logic [XLEN-1:0]          PCD,
   output logic [XLEN-1:0]          PCPlus4D,
   output logic                     ValidD
);

   localparam int unsigned CW  = $clog2(DEPTH) + 1;
   localparam int unsigned CW1 = CW + 1;

   logic [XLEN-1:0] fpc;          // next address to request
   logic [XLEN-1:0] rpc;          // PC of the next kept response
   logic [CW-1:0]   outstanding;  // accepted, not yet returned
   logic [CW-1:0]   discard;      // in-flight responses that are wrong-path
   logic [CW-1:0]   count;
   logic            empty;
   logic            full;
   logic            accept;
   logic            resp_keep;
   logic            bypass;
   logic            push;
   logic            pop;
   fetch_entry_t    head;
   fetch_entry_t    wentry;

   // Credit: queued + in-flight never exceeds DEPTH, so a push never finds the queue full
   assign imem.imem_req  = !rst && !PCSrcE && !full
                           && ((CW1'(count) + CW1'(outstanding)) < CW1'(DEPTH));
   assign imem.imem_addr = fpc;

   assign accept    = imem.imem_req && imem.imem_ready;
   assign resp_keep = imem.imem_rvalid && (discard == '0) && !PCSrcE;
   assign bypass    = resp_keep && empty && !StallD;
   assign push      = resp_keep && !bypass;
   assign pop       = !PCSrcE && !StallD && !empty;
   assign wentry    = '{instr: imem.imem_rdata, pc: rpc};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wentry),
      .pop   (pop),
      .rdata (head),
      .flush (PCSrcE),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   // Fetch PC, response tag PC and in-flight bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpc         <= RESET_PC;
         rpc         <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else if (PCSrcE) begin
         // No request is issued this cycle; everything still in flight is stale
         fpc         <= PCTargetE;
         rpc         <= PCTargetE;
         outstanding <= outstanding - CW'(imem.imem_rvalid);
         discard     <= outstanding - CW'(imem.imem_rvalid);
      end else begin
         if (accept)    fpc <= fpc + XLEN'(4);
         if (resp_keep) rpc <= rpc + XLEN'(4);
         if (imem.imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
         outstanding <= outstanding + CW'(accept) - CW'(imem.imem_rvalid);
      end
   end

   // IF/ID register: queue head first, else same-cycle bypass, else bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (PCSrcE) begin
         InstrD   <= NOP_INSTR;
         ValidD   <= 1'b0;
      end else if (!StallD) begin
         if (!empty) begin
            InstrD   <= head.instr;
            PCD      <= head.pc;
            PCPlus4D <= head.pc + XLEN'(4);
            ValidD   <= 1'b1;
         end else if (bypass) begin
            InstrD   <= imem.imem_rdata;
            PCD      <= rpc;
            PCPlus4D <= rpc + XLEN'(4);
            ValidD   <= 1'b1;
         end else begin
            InstrD   <= NOP_INSTR;
            ValidD   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Directed bench for fetch_prefetch_stage with a behavioural in-order
// instruction memory (configurable latency, optional ready toggling)
// that returns addr ^ 32'hA5A5_0000.
module tb_fetch_prefetch_stage;
   import fetch_pkg::*;

   localparam logic [31:0] KEY = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        StallD;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;

   int passed = 0;
   int total  = 0;

   fetch_prefetch_stage_if bus ();

   fetch_prefetch_stage #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .PCSrcE    (PCSrcE),
      .PCTargetE (PCTargetE),
      .StallD    (StallD),
      .imem      (bus),
      .InstrD    (InstrD),
      .PCD       (PCD),
      .PCPlus4D  (PCPlus4D),
      .ValidD    (ValidD)
   );

   always #5 clk = ~clk;

   // Memory model: decides each cycle at the falling edge
   int unsigned lat    = 1;
   bit          toggle = 1'b0;
   int unsigned cyc    = 0;
   logic [31:0] pend_addr [$];
   int unsigned pend_due  [$];

   always @(negedge clk or posedge rst) begin
      if (rst) begin
         pend_addr.delete();
         pend_due.delete();
         bus.imem_rvalid = 1'b0;
         bus.imem_ready  = 1'b0;
         bus.imem_rdata  = 32'h0;
      end else begin
         cyc++;
         bus.imem_rvalid = 1'b0;
         if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = pend_addr[0] ^ KEY;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
         bus.imem_ready = toggle ? cyc[0] : 1'b1;
         if (bus.imem_req && bus.imem_ready) begin
            pend_addr.push_back(bus.imem_addr);
            pend_due.push_back(cyc + lat);
         end
      end
   end

   // Structural invariants checked every cycle
   always @(posedge clk) begin
      if (rst === 1'b0) begin
         total++;
         if (dut.outstanding > 3'd4)
            $display("FAIL outstanding_bound: got %0d want <= 4", dut.outstanding);
         else passed++;
         total++;
         if (dut.push && dut.full && !dut.pop)
            $display("FAIL push_into_full: got push=1 full=1 want no push");
         else passed++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      PCSrcE    = 1'b0;
      StallD    = 1'b0;
      PCTargetE = 32'h0;
      rst       = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      PCSrcE = 1'b0; StallD = 1'b0; PCTargetE = 32'h0;
      lat = 1; toggle = 1'b0;
      rst = 1'b1;
      step();
      step();
      total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.imem_req); else passed++;
      total++; if (bus.imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", bus.imem_addr); else passed++;
      total++; if (InstrD !== NOP) $display("FAIL rst_instr: got %h want %h", InstrD, NOP); else passed++;
      total++; if (PCD !== 32'h0) $display("FAIL rst_pcd: got %h want 0", PCD); else passed++;
      total++; if (PCPlus4D !== 32'h0) $display("FAIL rst_pcplus4: got %h want 0", PCPlus4D); else passed++;
      total++; if (ValidD !== 1'b0) $display("FAIL rst_valid: got %b want 0", ValidD); else passed++;
      rst = 1'b0;
      #1;
      total++; if (bus.imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", bus.imem_req); else passed++;
   endtask

   // 1-cycle memory, no stall: first instruction two edges after release
   task automatic test_basic();
      step();
      total++; if (bus.imem_addr !== 32'h4) $display("FAIL basic_addr1: got %h want 4", bus.imem_addr); else passed++;
      total++; if (ValidD !== 1'b0) $display("FAIL basic_lat_valid: got %b want 0", ValidD); else passed++;
      for (int k = 0; k < 8; k++) begin
         step();
         total++; if (PCD !== 32'(4*k)) $display("FAIL basic_pcd: got %h want %h", PCD, 32'(4*k)); else passed++;
         total++; if (InstrD !== (32'(4*k) ^ KEY)) $display("FAIL basic_instr: got %h want %h", InstrD, 32'(4*k) ^ KEY); else passed++;
         total++; if (ValidD !== 1'b1) $display("FAIL basic_valid: got %b want 1", ValidD); else passed++;
         total++; if (PCPlus4D !== 32'(4*k+4)) $display("FAIL basic_pcplus4: got %h want %h", PCPlus4D, 32'(4*k+4)); else passed++;
      end
   endtask

   // Decode frozen at 0x1C for 6 cycles; queue fills to the credit limit
   task automatic test_stall();
      StallD = 1'b1;
      for (int i = 0; i < 6; i++) begin
         total++; if (bus.imem_req !== (i < 3)) $display("FAIL stall_req%0d: got %b want %b", i, bus.imem_req, (i < 3)); else passed++;
         step();
         total++; if (PCD !== 32'h1C) $display("FAIL stall_pcd: got %h want 1c", PCD); else passed++;
         total++; if (InstrD !== (32'h1C ^ KEY)) $display("FAIL stall_instr: got %h want %h", InstrD, 32'h1C ^ KEY); else passed++;
      end
      total++; if (dut.count !== 3'd4) $display("FAIL stall_count: got %0d want 4", dut.count); else passed++;
      StallD = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         total++; if (PCD !== 32'(28 + 4*k)) $display("FAIL unstall_pcd: got %h want %h", PCD, 32'(28 + 4*k)); else passed++;
         total++; if (ValidD !== 1'b1) $display("FAIL unstall_valid: got %b want 1", ValidD); else passed++;
      end
   endtask

   // Redirect to 0x40 with 3 entries queued and a response in flight
   task automatic test_redirect();
      StallD = 1'b1;
      step();
      total++; if (dut.count !== 3'd3) $display("FAIL redir_pre_count: got %0d want 3", dut.count); else passed++;
      total++; if (PCD !== 32'h3C) $display("FAIL redir_pre_pcd: got %h want 3c", PCD); else passed++;
      PCSrcE = 1'b1; PCTargetE = 32'h40; StallD = 1'b0;
      #1;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL redir_req: got %b want 0", bus.imem_req); else passed++;
      step();
      PCSrcE = 1'b0;
      total++; if (ValidD !== 1'b0) $display("FAIL redir_bubble1: got %b want 0", ValidD); else passed++;
      total++; if (InstrD !== NOP) $display("FAIL redir_nop: got %h want %h", InstrD, NOP); else passed++;
      total++; if (PCD !== 32'h3C) $display("FAIL redir_pcd_hold: got %h want 3c", PCD); else passed++;
      total++; if (bus.imem_addr !== 32'h40) $display("FAIL redir_addr: got %h want 40", bus.imem_addr); else passed++;
      step();
      total++; if (ValidD !== 1'b0) $display("FAIL redir_bubble2: got %b want 0", ValidD); else passed++;
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (PCD !== 32'(32'h40 + 4*k)) $display("FAIL redir_pcd: got %h want %h", PCD, 32'(32'h40 + 4*k)); else passed++;
         total++; if (InstrD !== (32'(32'h40 + 4*k) ^ KEY)) $display("FAIL redir_instr: got %h want %h", InstrD, 32'(32'h40 + 4*k) ^ KEY); else passed++;
         total++; if (ValidD !== 1'b1) $display("FAIL redir_valid: got %b want 1", ValidD); else passed++;
      end
   endtask

   // 3-cycle memory with ready toggling: strict in-order, gap-free PCs
   task automatic test_slow_memory();
      logic [31:0] exp_pc;
      int          nvalid;
      lat = 3; toggle = 1'b1;
      apply_reset();
      exp_pc = 32'h0;
      nvalid = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (ValidD === 1'b1) begin
            total++; if (PCD !== exp_pc) $display("FAIL slow_pcd: got %h want %h", PCD, exp_pc); else passed++;
            total++; if (InstrD !== (exp_pc ^ KEY)) $display("FAIL slow_instr: got %h want %h", InstrD, exp_pc ^ KEY); else passed++;
            exp_pc = exp_pc + 32'd4;
            nvalid++;
         end else begin
            total++; if (InstrD !== NOP) $display("FAIL slow_bubble: got %h want %h", InstrD, NOP); else passed++;
         end
      end
      total++; if (nvalid < 15) $display("FAIL slow_progress: got %0d want >= 15", nvalid); else passed++;
   endtask

   // Redirect and stall together under 3-cycle memory: redirect wins, 2 stale dropped
   task automatic test_redirect_stall();
      toggle = 1'b0;
      repeat (10) step();
      PCSrcE = 1'b1; StallD = 1'b1; PCTargetE = 32'h100;
      #1;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL rs_req: got %b want 0", bus.imem_req); else passed++;
      step();
      PCSrcE = 1'b0; StallD = 1'b0;
      total++; if (ValidD !== 1'b0) $display("FAIL rs_valid: got %b want 0", ValidD); else passed++;
      total++; if (InstrD !== NOP) $display("FAIL rs_nop: got %h want %h", InstrD, NOP); else passed++;
      total++; if (dut.discard !== 3'd2) $display("FAIL rs_discard: got %0d want 2", dut.discard); else passed++;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (ValidD !== 1'b0) $display("FAIL rs_bubble%0d: got %b want 0", i, ValidD); else passed++;
      end
      for (int k = 0; k < 2; k++) begin
         step();
         total++; if (PCD !== 32'(32'h100 + 4*k)) $display("FAIL rs_pcd: got %h want %h", PCD, 32'(32'h100 + 4*k)); else passed++;
         total++; if (InstrD !== (32'(32'h100 + 4*k) ^ KEY)) $display("FAIL rs_instr: got %h want %h", InstrD, 32'(32'h100 + 4*k) ^ KEY); else passed++;
         total++; if (ValidD !== 1'b1) $display("FAIL rs_valid2: got %b want 1", ValidD); else passed++;
      end
   endtask

   // Asynchronous reset with a full queue, then restart from RESET_PC
   task automatic test_reset_midop();
      lat = 1; toggle = 1'b0;
      apply_reset();
      step(); step(); step(); step();
      total++; if (PCD !== 32'h8) $display("FAIL mid_pre_pcd: got %h want 8", PCD); else passed++;
      StallD = 1'b1;
      repeat (6) step();
      total++; if (dut.count !== 3'd4) $display("FAIL mid_full: got %0d want 4", dut.count); else passed++;
      #2;
      rst = 1'b1;
      #1;
      total++; if (InstrD !== NOP) $display("FAIL mid_instr: got %h want %h", InstrD, NOP); else passed++;
      total++; if (PCD !== 32'h0) $display("FAIL mid_pcd: got %h want 0", PCD); else passed++;
      total++; if (PCPlus4D !== 32'h0) $display("FAIL mid_pcplus4: got %h want 0", PCPlus4D); else passed++;
      total++; if (ValidD !== 1'b0) $display("FAIL mid_valid: got %b want 0", ValidD); else passed++;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL mid_req: got %b want 0", bus.imem_req); else passed++;
      total++; if (bus.imem_addr !== 32'h0) $display("FAIL mid_addr: got %h want 0", bus.imem_addr); else passed++;
      total++; if (dut.count !== 3'd0) $display("FAIL mid_count: got %0d want 0", dut.count); else passed++;
      step();
      rst = 1'b0; StallD = 1'b0;
      #1;
      total++; if (bus.imem_req !== 1'b1) $display("FAIL mid_restart_req: got %b want 1", bus.imem_req); else passed++;
      step();
      total++; if (ValidD !== 1'b0) $display("FAIL mid_restart_lat: got %b want 0", ValidD); else passed++;
      for (int k = 0; k < 2; k++) begin
         step();
         total++; if (PCD !== 32'(4*k)) $display("FAIL mid_restart_pcd: got %h want %h", PCD, 32'(4*k)); else passed++;
         total++; if (ValidD !== 1'b1) $display("FAIL mid_restart_valid: got %b want 1", ValidD); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_slow_memory();
      test_redirect_stall();
      test_reset_midop();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
